// File: rtl/cpu_perf_pkg.sv
// Shared definitions for the CPU performance monitor: run/stop state encoding,
// counter limit modes and the read-select width calculation.
package cpu_perf_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUN     = 1'b1
  } state_t;

  localparam int MODE_WRAP = 32'sd0;
  localparam int MODE_SAT  = 32'sd1;

  // Index 0 is the cycle counter, so NUM_EVENTS event counters need NUM_EVENTS+1 codes.
  function automatic int calc_sel_w(input int num_events);
    return (num_events < 32'sd1) ? 32'sd1 : $clog2(num_events + 32'sd1);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One live counter with a sticky limit flag; wraps or saturates at all-ones.
module perf_counter
  import cpu_perf_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int SAT_MODE  = MODE_WRAP
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 at_max_s;
  logic [CNT_WIDTH-1:0] next_val_s;

  // Next count value, including the limit behaviour on an increment at all-ones.
  always_comb begin
    at_max_s = (value == CNT_MAX);
    if (!inc) begin
      next_val_s = value;
    end else if (!at_max_s) begin
      next_val_s = value + CNT_ONE;
    end else if (SAT_MODE == MODE_SAT) begin
      next_val_s = CNT_MAX;
    end else begin
      next_val_s = CNT_ZERO;
    end
  end

  // Counter and sticky flag; a clear overrides any same-cycle increment.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      value <= CNT_ZERO;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= CNT_ZERO;
      ovf   <= 1'b0;
    end else begin
      value <= next_val_s;
      ovf   <= ovf | (inc & at_max_s);
    end
  end

endmodule

// File: rtl/cpu_perf_monitor.sv
// Performance monitor: cycle + event counters, a shadow bank loaded on SNAPSHOT,
// and a one-cycle-latency read port over the shadow bank.
module cpu_perf_monitor
  import cpu_perf_pkg::*;
#(
  parameter int  NUM_EVENTS = 4,
  parameter int  CNT_WIDTH  = 32,
  parameter int  SAT_MODE   = MODE_WRAP,
  localparam int SEL_W      = calc_sel_w(NUM_EVENTS)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CLEAR,
  input  logic                  SNAPSHOT,
  input  logic [NUM_EVENTS-1:0] EVENT_IN,
  input  logic                  RD_EN,
  input  logic [SEL_W-1:0]      RD_SEL,
  output logic [CNT_WIDTH-1:0]  RD_DATA,
  output logic                  RD_OVF,
  output logic                  RD_VALID,
  output logic                  RUNNING,
  output logic                  SNAP_VALID
);

  localparam int NUM_CNT = NUM_EVENTS + 32'sd1;

  state_t               state_r;
  logic                 running_r;
  logic                 snap_valid_r;
  logic                 run_s;
  logic [NUM_CNT-1:0]   inc_s;
  logic [CNT_WIDTH-1:0] live_val_s   [NUM_CNT];
  logic [NUM_CNT-1:0]   live_ovf_s;
  logic [CNT_WIDTH-1:0] shadow_val_r [NUM_CNT];
  logic [NUM_CNT-1:0]   shadow_ovf_r;
  logic [CNT_WIDTH-1:0] rd_val_s;
  logic                 rd_ovf_s;
  logic [CNT_WIDTH-1:0] rd_data_r;
  logic                 rd_ovf_r;
  logic                 rd_valid_r;

  // Increments follow the pre-edge state: START-cycle events are dropped, STOP-cycle events kept.
  always_comb begin
    run_s = (state_r == RUN);
    inc_s = {EVENT_IN & {NUM_EVENTS{run_s}}, run_s};
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .SAT_MODE  (SAT_MODE)
    ) u_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .clr   (CLEAR),
      .inc   (inc_s[i]),
      .value (live_val_s[i]),
      .ovf   (live_ovf_s[i])
    );
  end

  // Run/stop control with registered RUNNING; STOP beats a simultaneous START.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= STOPPED;
      running_r <= 1'b0;
    end else begin
      case (state_r)
        STOPPED: begin
          if (START && !STOP) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= STOPPED;
            running_r <= 1'b0;
          end
        end
        RUN: begin
          if (STOP) begin
            state_r   <= STOPPED;
            running_r <= 1'b0;
          end else begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= STOPPED;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  // Shadow bank captures the pre-edge live values; CLEAR leaves it untouched.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_val_r[i] <= {CNT_WIDTH{1'b0}};
      end
      shadow_ovf_r <= {NUM_CNT{1'b0}};
    end else if (SNAPSHOT) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_val_r[i] <= live_val_s[i];
      end
      shadow_ovf_r <= live_ovf_s;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_val_r[i] <= shadow_val_r[i];
      end
      shadow_ovf_r <= shadow_ovf_r;
    end
  end

  // SNAP_VALID: a snapshot sets it even when CLEAR arrives in the same cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      snap_valid_r <= 1'b0;
    end else if (SNAPSHOT) begin
      snap_valid_r <= 1'b1;
    end else if (CLEAR) begin
      snap_valid_r <= 1'b0;
    end else begin
      snap_valid_r <= snap_valid_r;
    end
  end

  // One-hot select over the shadow bank; indices past the last counter read as zero.
  always_comb begin
    rd_val_s = {CNT_WIDTH{1'b0}};
    rd_ovf_s = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      rd_val_s = rd_val_s | (shadow_val_r[i] & {CNT_WIDTH{RD_SEL == SEL_W'(i)}});
      rd_ovf_s = rd_ovf_s | (shadow_ovf_r[i] & (RD_SEL == SEL_W'(i)));
    end
  end

  // Read port register: data holds between reads, valid pulses for one cycle per request.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_data_r  <= {CNT_WIDTH{1'b0}};
      rd_ovf_r   <= 1'b0;
      rd_valid_r <= 1'b0;
    end else if (RD_EN) begin
      rd_data_r  <= rd_val_s;
      rd_ovf_r   <= rd_ovf_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_data_r  <= rd_data_r;
      rd_ovf_r   <= rd_ovf_r;
      rd_valid_r <= 1'b0;
    end
  end

  assign RD_DATA    = rd_data_r;
  assign RD_OVF     = rd_ovf_r;
  assign RD_VALID   = rd_valid_r;
  assign RUNNING    = running_r;
  assign SNAP_VALID = snap_valid_r;

endmodule

// File: tb/tb_cpu_perf_monitor.sv
// Bench for cpu_perf_monitor: a 32-bit wrapping instance plus 8-bit wrap and
// saturate instances sharing the same stimulus; read results go through a scoreboard.
module tb_cpu_perf_monitor;

  localparam int NE = 4;
  localparam int SW = 3;

  logic          CLK;
  logic          RESET;
  logic          START;
  logic          STOP;
  logic          CLEAR;
  logic          SNAPSHOT;
  logic [NE-1:0] EVENT_IN;
  logic          RD_EN;
  logic [SW-1:0] RD_SEL;

  logic [31:0] RD_DATA;
  logic        RD_OVF, RD_VALID, RUNNING, SNAP_VALID;
  logic [7:0]  w_data, s_data;
  logic        w_ovf, w_valid, w_running, w_snap;
  logic        s_ovf, s_valid, s_running, s_snap;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
    logic [7:0]  wd;
    logic        wo;
    logic [7:0]  sd;
    logic        so;
    logic        chk8;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  cpu_perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(32), .SAT_MODE(0)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .SNAPSHOT(SNAPSHOT), .EVENT_IN(EVENT_IN), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
    .RD_DATA(RD_DATA), .RD_OVF(RD_OVF), .RD_VALID(RD_VALID),
    .RUNNING(RUNNING), .SNAP_VALID(SNAP_VALID));

  cpu_perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(8), .SAT_MODE(0)) dut_w8 (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .SNAPSHOT(SNAPSHOT), .EVENT_IN(EVENT_IN), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
    .RD_DATA(w_data), .RD_OVF(w_ovf), .RD_VALID(w_valid),
    .RUNNING(w_running), .SNAP_VALID(w_snap));

  cpu_perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(8), .SAT_MODE(1)) dut_s8 (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .SNAPSHOT(SNAPSHOT), .EVENT_IN(EVENT_IN), .RD_EN(RD_EN), .RD_SEL(RD_SEL),
    .RD_DATA(s_data), .RD_OVF(s_ovf), .RD_VALID(s_valid),
    .RUNNING(s_running), .SNAP_VALID(s_snap));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t mk_exp(input logic [31:0] d, input logic o);
    exp_t e;
    e = '0;
    e.d = d;
    e.o = o;
    return e;
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic pulse_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  task automatic pulse_snapshot();
    SNAPSHOT = 1'b1;
    tick();
    SNAPSHOT = 1'b0;
  endtask

  // START (with all events high, which must not count), then n counted cycles, the last carrying STOP.
  task automatic run_cycles(input int n, input logic [31:0] pat, input int ch);
    START = 1'b1;
    EVENT_IN = 4'b1111;
    tick();
    START = 1'b0;
    for (int i = 0; i < n; i++) begin
      EVENT_IN = 4'b0000;
      if (i < 32) EVENT_IN[ch] = pat[i];
      STOP = (i == n - 1);
      tick();
    end
    STOP = 1'b0;
    EVENT_IN = 4'b0000;
  endtask

  task automatic drive_read(input logic [SW-1:0] sel, input exp_t e);
    exp_q.push_back(e);
    RD_SEL = sel;
    RD_EN = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({RUNNING, SNAP_VALID, RD_VALID, RD_OVF} !== 4'b0000 || RD_DATA !== 32'd0) begin
      errors++;
      $display("FAIL reset_during: run=%0b snap=%0b valid=%0b ovf=%0b data=%0d, expected all 0",
               RUNNING, SNAP_VALID, RD_VALID, RD_OVF, RD_DATA);
    end
    #8 RESET = 1'b1;
    tick();
    checks++;
    if ({RUNNING, SNAP_VALID, RD_VALID} !== 3'b000) begin
      errors++;
      $display("FAIL reset_after: run=%0b snap=%0b valid=%0b, expected 0 0 0", RUNNING, SNAP_VALID, RD_VALID);
    end
  endtask

  task automatic test_cycle_count();
    exp_t e;
    run_cycles(10, 32'd0, 0);
    checks++;
    if (RUNNING !== 1'b0) begin
      errors++;
      $display("FAIL cyc_stopped: RUNNING=%0b, expected 0", RUNNING);
    end
    pulse_snapshot();
    drive_read(3'd0, mk_exp(32'd10, 1'b0));
    checks++;
    if (RD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL cyc_latency: RD_VALID=%0b in request cycle, expected 0", RD_VALID);
    end
    tick();
    RD_EN = 1'b0;
    checks++;
    if (RD_VALID !== 1'b1) begin
      errors++;
      $display("FAIL cyc_valid: RD_VALID=%0b, expected 1", RD_VALID);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (RD_DATA !== e.d || RD_OVF !== e.o) begin
        errors++;
        $display("FAIL cyc_data: got %0d/%0b, expected %0d/%0b", RD_DATA, RD_OVF, e.d, e.o);
      end
    end
  endtask

  // Also exercises back-to-back reads across the whole bank.
  task automatic test_event_count();
    logic [31:0] pat;
    logic [31:0] exp_v [5];
    exp_t e;
    pat = 32'b1011_0100_1101;
    pulse_clear();
    run_cycles(12, pat, 1);
    pulse_snapshot();
    exp_v = '{32'd12, 32'd0, 32'($countones(pat[11:0])), 32'd0, 32'd0};
    for (int k = 0; k < 5; k++) begin
      drive_read(SW'(k), mk_exp(exp_v[k], 1'b0));
      tick();
      checks++;
      if (RD_VALID !== 1'b1) begin
        errors++;
        $display("FAIL ev_valid[%0d]: RD_VALID=%0b, expected 1", k, RD_VALID);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (RD_DATA !== e.d || RD_OVF !== e.o) begin
          errors++;
          $display("FAIL ev_data[%0d]: got %0d/%0b, expected %0d/%0b", k, RD_DATA, RD_OVF, e.d, e.o);
        end
      end
    end
    RD_EN = 1'b0;
  endtask

  task automatic test_overflow();
    int   n;
    exp_t e;
    n = 257;
    pulse_clear();
    checks++;
    if (SNAP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear_snapvalid: SNAP_VALID=%0b, expected 0", SNAP_VALID);
    end
    run_cycles(n, 32'd0, 0);
    pulse_snapshot();
    e = mk_exp(32'(n), 1'b0);
    e.wd = 8'(n % 256);
    e.wo = (n > 255);
    e.sd = (n > 255) ? 8'd255 : 8'(n);
    e.so = (n > 255);
    e.chk8 = 1'b1;
    drive_read(3'd0, e);
    tick();
    RD_EN = 1'b0;
    checks++;
    if ({RD_VALID, w_valid, s_valid, w_snap, s_snap} !== 5'b11111 || {w_running, s_running} !== 2'b00) begin
      errors++;
      $display("FAIL ovf_valid: valid=%0b%0b%0b snap=%0b%0b run=%0b%0b, expected 11111 00",
               RD_VALID, w_valid, s_valid, w_snap, s_snap, w_running, s_running);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (RD_DATA !== e.d || RD_OVF !== e.o) begin
        errors++;
        $display("FAIL ovf_w32: got %0d/%0b, expected %0d/%0b", RD_DATA, RD_OVF, e.d, e.o);
      end
      checks++;
      if (e.chk8 && (w_data !== e.wd || w_ovf !== e.wo)) begin
        errors++;
        $display("FAIL ovf_wrap8: got %0d/%0b, expected %0d/%0b", w_data, w_ovf, e.wd, e.wo);
      end
      checks++;
      if (e.chk8 && (s_data !== e.sd || s_ovf !== e.so)) begin
        errors++;
        $display("FAIL ovf_sat8: got %0d/%0b, expected %0d/%0b", s_data, s_ovf, e.sd, e.so);
      end
    end
  endtask

  // SNAPSHOT+CLEAR together, with a same-cycle read that must see the previous shadow value.
  task automatic test_snap_clear();
    exp_t e;
    logic [31:0] exp_v [3];
    pulse_clear();
    run_cycles(42, 32'd0, 0);
    exp_v = '{32'd257, 32'd42, 32'd3};
    SNAPSHOT = 1'b1;
    CLEAR = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        RD_EN = 1'b0;
        run_cycles(3, 32'd0, 0);
        pulse_snapshot();
      end
      drive_read(3'd0, mk_exp(exp_v[k], 1'b0));
      tick();
      SNAPSHOT = 1'b0;
      CLEAR = 1'b0;
      checks++;
      if (RD_VALID !== 1'b1 || SNAP_VALID !== 1'b1) begin
        errors++;
        $display("FAIL sc_valid[%0d]: RD_VALID=%0b SNAP_VALID=%0b, expected 1 1", k, RD_VALID, SNAP_VALID);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (RD_DATA !== e.d || RD_OVF !== e.o) begin
          errors++;
          $display("FAIL sc_data[%0d]: got %0d/%0b, expected %0d/%0b", k, RD_DATA, RD_OVF, e.d, e.o);
        end
      end
    end
    RD_EN = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (3) tick();
    checks++;
    if (RUNNING !== 1'b1) begin
      errors++;
      $display("FAIL ar_running_before: RUNNING=%0b, expected 1", RUNNING);
    end
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({RUNNING, SNAP_VALID, RD_VALID, RD_OVF} !== 4'b0000 || RD_DATA !== 32'd0) begin
      errors++;
      $display("FAIL ar_immediate: run=%0b snap=%0b valid=%0b ovf=%0b data=%0d, expected all 0",
               RUNNING, SNAP_VALID, RD_VALID, RD_OVF, RD_DATA);
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        RD_EN = 1'b0;
        run_cycles(5, 32'd0, 0);
        pulse_snapshot();
      end
      drive_read((k == 5) ? 3'd0 : SW'(k), mk_exp((k == 5) ? 32'd5 : 32'd0, 1'b0));
      tick();
      checks++;
      if (RD_VALID !== 1'b1) begin
        errors++;
        $display("FAIL ar_valid[%0d]: RD_VALID=%0b, expected 1", k, RD_VALID);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (RD_DATA !== e.d || RD_OVF !== e.o) begin
          errors++;
          $display("FAIL ar_data[%0d]: got %0d/%0b, expected %0d/%0b", k, RD_DATA, RD_OVF, e.d, e.o);
        end
      end
    end
    RD_EN = 1'b0;
  endtask

  // Out-of-range selects, read-data hold, and START+STOP in one cycle.
  task automatic test_read_bounds();
    exp_t e;
    logic [SW-1:0] sels  [5];
    logic [31:0]   exp_v [5];
    sels  = '{3'd5, 3'd7, 3'd0, 3'd0, 3'd0};
    exp_v = '{32'd0, 32'd0, 32'd5, 32'd0, 32'd5};
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        RD_EN = 1'b0;
        tick();
        checks++;
        if (RD_VALID !== 1'b0 || RD_DATA !== 32'd5) begin
          errors++;
          $display("FAIL rb_hold: valid=%0b data=%0d, expected 0 and 5", RD_VALID, RD_DATA);
        end
        START = 1'b1;
        STOP = 1'b1;
        EVENT_IN = 4'b1111;
        tick();
        START = 1'b0;
        STOP = 1'b0;
        EVENT_IN = 4'b0000;
        checks++;
        if (RUNNING !== 1'b0) begin
          errors++;
          $display("FAIL rb_start_stop: RUNNING=%0b, expected 0", RUNNING);
        end
        repeat (3) tick();
        pulse_snapshot();
        continue;
      end
      drive_read(sels[k], mk_exp(exp_v[k], 1'b0));
      tick();
      checks++;
      if (RD_VALID !== 1'b1) begin
        errors++;
        $display("FAIL rb_valid[%0d]: RD_VALID=%0b, expected 1", k, RD_VALID);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (RD_DATA !== e.d || RD_OVF !== e.o) begin
          errors++;
          $display("FAIL rb_data[%0d]: sel=%0d got %0d/%0b, expected %0d/%0b",
                   k, sels[k], RD_DATA, RD_OVF, e.d, e.o);
        end
      end
    end
    RD_EN = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    START = 1'b0;
    STOP = 1'b0;
    CLEAR = 1'b0;
    SNAPSHOT = 1'b0;
    EVENT_IN = 4'b0000;
    RD_EN = 1'b0;
    RD_SEL = 3'd0;
    test_reset();
    test_cycle_count();
    test_event_count();
    test_overflow();
    test_snap_clear();
    test_async_reset();
    test_read_bounds();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_perf_monitor.md
Name: cpu_perf_monitor

Overview:
- Synthesizable performance/event monitor for the RV32IM pipelined CPU.
- Counts cycles plus NUM_EVENTS event lines, for example instruction retire, BUSYWAIT stall, MEM_READ and MEM_WRITE.
- A free-running counter bank is copied into a shadow bank on command. A single read port returns one shadow counter per request.
- Instantiated beside the CPU core so that CPU_tb can read hardware counts instead of relying on $monitor.

Parameters:
- NUM_EVENTS, 4: number of event input channels (1..15).
- CNT_WIDTH, 32: width of every counter (8..64).
- SAT_MODE, 0: counter limit mode. 0 = wrap to 0 at max; 1 = saturate at max.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle pulse: begin counting.
- STOP  input  1  one-cycle pulse: halt counting.
- CLEAR  input  1  one-cycle pulse: zero the live counters and overflow flags.
- SNAPSHOT  input  1  one-cycle pulse: copy live counters and flags to the shadow bank.
- EVENT_IN  input  NUM_EVENTS  per-cycle event strobes; bit i drives counter i+1.
- RD_EN  input  1  read request.
- RD_SEL  input  SEL_W  counter index. SEL_W = $clog2(NUM_EVENTS+1). Index 0 = cycle counter.
- RD_DATA  output  CNT_WIDTH  shadow value of the selected counter.
- RD_OVF  output  1  shadow overflow flag of the selected counter.
- RD_VALID  output  1  RD_DATA/RD_OVF valid this cycle.
- RUNNING  output  1  high while in the RUN state.
- SNAP_VALID  output  1  high once at least one snapshot has been taken since reset or CLEAR.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=STOPPED.
  - All live and shadow counters = 0; all flags = 0.
  - RD_DATA=0, RD_OVF=0, RD_VALID=0, RUNNING=0, SNAP_VALID=0.
  - Reset applied mid-run discards all counts immediately.
- States: STOPPED and RUN.
  - STOPPED -> RUN on START.
  - RUN -> STOPPED on STOP.
  - If START and STOP arrive together, STOP wins.
  - RUNNING is a registered copy of the state, so it rises one cycle after START is sampled.
- Counting happens in RUN only. Each cycle:
  - counter 0 increments by 1.
  - counter i+1 increments by 1 when EVENT_IN[i]=1.
  - In STOPPED, counters hold.
  - An event in the same cycle as the START pulse is not counted.
  - An event in the same cycle as the STOP pulse is counted.
- Limit behaviour (per counter, on an increment at all-ones):
  - SAT_MODE=0: counter goes to 0 and its sticky ovf flag is set.
  - SAT_MODE=1: counter holds all-ones and its sticky ovf flag is set.
  - A flag stays set until CLEAR or reset.
- CLEAR:
  - Zeroes live counters and live flags, and clears SNAP_VALID.
  - Does not touch the shadow bank or the state.
  - CLEAR beats any same-cycle increment: the result is 0.
- SNAPSHOT:
  - Copies the pre-edge live values and flags (before that cycle's increment or clear) into the shadow bank, and sets SNAP_VALID.
  - SNAPSHOT together with CLEAR gives shadow = old values and live = 0.
  - In that case SNAP_VALID ends at 1, because SNAPSHOT wins over CLEAR for this flag.
- Read timing:
  - RD_EN sampled at edge N gives RD_VALID=1 with data from shadow[RD_SEL] in cycle N+1. Latency is 1 cycle.
  - Data reflects the shadow contents before edge N's snapshot. A read issued in the same cycle as SNAPSHOT returns the old shadow value.
  - RD_SEL > NUM_EVENTS returns RD_DATA=0, RD_OVF=0, RD_VALID=1.
  - Back-to-back reads are allowed, one per cycle.
  - RD_DATA holds its last value when RD_EN=0; RD_VALID=0 in that case.
- Widths: all arithmetic is unsigned CNT_WIDTH. There is no carry beyond CNT_WIDTH; the flag captures it.

Decomposition:
- Package cpu_perf_pkg holds:
  - the state encoding (STOPPED=1'b0, RUN=1'b1);
  - the SEL_W computation function;
  - the SAT_MODE constants (MODE_WRAP=0, MODE_SAT=1).
- Sub-module perf_counter (parameters CNT_WIDTH, SAT_MODE):
  - Inputs: CLK, RESET, clr, inc. Outputs: value, ovf.
  - Instantiated NUM_EVENTS+1 times via generate.
  - Shadow bank, read mux and FSM live in the top level.

Test Plan:
1. Reset low for 11 ns, then START, 10 cycles of RUN, STOP, SNAPSHOT, then read index 0 -> RD_DATA=10, RD_OVF=0, RD_VALID one cycle after RD_EN.
2. In RUN, EVENT_IN[1] high on 7 of 12 cycles, then SNAPSHOT and read index 2 -> 7. Index 1 (EVENT_IN[0] held 0) -> 0.
3. CNT_WIDTH=8, SAT_MODE=0, 257 cycles of RUN, then SNAPSHOT and read index 0 -> RD_DATA=1, RD_OVF=1. Same with SAT_MODE=1 -> RD_DATA=255, RD_OVF=1.
4. SNAPSHOT and CLEAR in the same cycle with live counter 0 = 42 -> shadow 0 reads 42, the next snapshot after 3 RUN cycles reads 3, and SNAP_VALID stays 1.
5. RESET driven low asynchronously mid-RUN (between edges) -> RUNNING=0, SNAP_VALID=0, and reads of all indices return 0. Then START, 5 cycles, SNAPSHOT, read index 0 -> 5.
6. Read RD_SEL=NUM_EVENTS+1 -> RD_DATA=0, RD_VALID=1. START+STOP in the same cycle -> RUNNING stays 0 and counters unchanged.
